// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the debounce_bank key debouncer.
//   MODE_ANY  - stretch: level is 1 while any history sample is 1
//   MODE_ALL  - level is 1 only while every history sample is 1
//   MODE_HYST - set on all-ones, clear on all-zeros, otherwise hold
//   clog2()   - ceiling log2, never less than 1, for sizing counters
package debounce_pkg;

  localparam int MODE_ANY  = 0;
  localparam int MODE_ALL  = 1;
  localparam int MODE_HYST = 2;

  // Ceiling log2 of value, clamped to a minimum width of one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one debounced key channel.
//   Two-flop synchroniser (with optional polarity inversion), DEPTH-sample
//   history, MODE decision rule, registered level and press/release pulses.
//   With KEY_REPEAT_EN defined, an auto-repeat counter adds extra press
//   pulses while the key is held; otherwise press fires only on a rise.
// Ports:
//   clk400Hz   in   400 Hz sample clock, rising edge
//   rst        in   asynchronous active-high reset
//   raw        in   raw asynchronous key input
//   next_level out  combinational next value of level (feeds the bank summary)
//   level      out  registered debounced state, 1 = pressed
//   press      out  one-cycle pulse on a rise or an auto-repeat
//   released   out  one-cycle pulse on a fall ("release" is a reserved word)
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MODE       = MODE_HYST,
  parameter int ACTIVE_LOW = 0
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 40
`endif
) (
  input  logic clk400Hz,
  input  logic rst,
  input  logic raw,
  output logic next_level,
  output logic level,
  output logic press,
  output logic released
);

  localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             s0_r;
  logic             s1_r;
  logic [DEPTH-1:0] hist_r;
  logic             level_r;
  logic             press_r;
  logic             rel_r;
  logic             next_lv_s;
  logic             rise_s;
  logic             fall_s;
  logic             repeat_s;

  // Synchroniser and sample history; history holds logical (polarity-corrected) samples.
  always_ff @(posedge clk400Hz or posedge rst) begin
    if (rst) begin
      s0_r   <= 1'b0;
      s1_r   <= 1'b0;
      hist_r <= {DEPTH{1'b0}};
    end else begin
      s0_r   <= raw ^ POL;
      s1_r   <= s0_r;
      hist_r <= {hist_r[DEPTH-2:0], s1_r};
    end
  end

  // Decision rule applied to the current history.
  always_comb begin
    next_lv_s = 1'b0;
    case (MODE)
      MODE_ANY: next_lv_s = |hist_r;
      MODE_ALL: next_lv_s = &hist_r;
      MODE_HYST: begin
        if (&hist_r) begin
          next_lv_s = 1'b1;
        end else if (~|hist_r) begin
          next_lv_s = 1'b0;
        end else begin
          next_lv_s = level_r;
        end
      end
      default: next_lv_s = level_r;
    endcase
  end

  assign rise_s = next_lv_s & ~level_r;
  assign fall_s = ~next_lv_s & level_r;

`ifdef KEY_REPEAT_EN
  localparam int               CNT_W      = clog2(REPEAT_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_HIT    = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  // A repeat fires on the cycle the count would reach REPEAT_DELAY while the key stays down.
  assign repeat_s  = level_r & next_lv_s & (cnt_inc_s == CNT_HIT);

  // Auto-repeat counter: zero while released or on the rise, counts while held.
  always_ff @(posedge clk400Hz or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (level_r & next_lv_s) begin
      if (repeat_s) begin
        cnt_r <= CNT_RELOAD;
      end else begin
        cnt_r <= cnt_inc_s;
      end
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // Registered level and edge pulses; a repeat needs next_lv=1, a fall needs next_lv=0.
  always_ff @(posedge clk400Hz or posedge rst) begin
    if (rst) begin
      level_r <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      level_r <= next_lv_s;
      press_r <= rise_s | repeat_s;
      rel_r   <= fall_s;
    end
  end

  assign next_level = next_lv_s;
  assign level      = level_r;
  assign press      = press_r;
  assign released   = rel_r;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH-channel front-panel key debouncer on the 400 Hz tick clock.
//   Each channel is an independent debounce_chan; any_pressed is the registered
//   OR of every channel's next level, so it lines up with level.
//   Optional feature macro: KEY_REPEAT_EN (per-channel auto-repeat press pulses).
// Ports:
//   clk400Hz    in   400 Hz sample clock, rising edge
//   rst         in   asynchronous active-high reset
//   in          in   [N_CH] raw asynchronous key inputs
//   level       out  [N_CH] debounced key state, 1 = pressed
//   press       out  [N_CH] one-cycle press pulses (plus repeats)
//   released    out  [N_CH] one-cycle release pulses ("release" is a reserved word)
//   any_pressed out  OR of level, registered
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEPTH        = 4,
  parameter int MODE         = MODE_HYST,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 40
) (
  input  logic            clk400Hz,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic            any_pressed
);

  logic [N_CH-1:0] next_level_s;
  logic            any_r;

  // Reject parameter sets the channel logic cannot honour.
  if (DEPTH < 2 || MODE < MODE_ANY || MODE > MODE_HYST ||
      REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("debounce_bank: illegal parameter set");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DEPTH        (DEPTH),
      .MODE         (MODE),
      .ACTIVE_LOW   (ACTIVE_LOW)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_chan (
      .clk400Hz   (clk400Hz),
      .rst        (rst),
      .raw        (in[i]),
      .next_level (next_level_s[i]),
      .level      (level[i]),
      .press      (press[i]),
      .released   (released[i])
    );
  end

  // Summary flag built from next levels so it changes on the same edge as level.
  always_ff @(posedge clk400Hz or posedge rst) begin
    if (rst) begin
      any_r <= 1'b0;
    end else begin
      any_r <= |next_level_s;
    end
  end

  assign any_pressed = any_r;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: four instances (HYST, ALL, ANY active-low,
// HYST with short repeat timing), directed tables/sequences plus random stimulus
// compared each edge against a sample-window reference model.
module tb_debounce_bank;

  localparam int DEPTH = 4;
  localparam int N_DUT = 4;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] in_d  [N_DUT];
  logic [3:0] lv_d  [N_DUT];
  logic [3:0] pr_d  [N_DUT];
  logic [3:0] rl_d  [N_DUT];
  logic       any_d [N_DUT];

  int checks = 0;
  int errors = 0;

  // Reference model configuration and state.
  int   m_mode  [N_DUT] = '{2, 1, 0, 2};
  logic m_al    [N_DUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int   m_delay [N_DUT] = '{200, 200, 200, 8};
  int   m_rate  [N_DUT] = '{40, 40, 40, 3};
  logic [15:0] samp [N_DUT][4];
  int          held [N_DUT][4];
  logic [3:0]  lv_m [N_DUT];
  logic [3:0]  pr_m [N_DUT];
  logic [3:0]  rl_m [N_DUT];
  logic        any_m [N_DUT];
  int          hold_cnt [N_DUT][4];

  typedef struct {
    int         n;
    logic [3:0] in;
    logic [3:0] lv;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       any;
  } vec_t;
  vec_t tbl [7];

  debounce_bank #(.N_CH(4), .DEPTH(DEPTH), .MODE(2), .ACTIVE_LOW(0), .REPEAT_DELAY(200), .REPEAT_RATE(40)) u_hyst (
    .clk400Hz(clk), .rst(rst), .in(in_d[0]), .level(lv_d[0]), .press(pr_d[0]), .released(rl_d[0]), .any_pressed(any_d[0]));
  debounce_bank #(.N_CH(4), .DEPTH(DEPTH), .MODE(1), .ACTIVE_LOW(0), .REPEAT_DELAY(200), .REPEAT_RATE(40)) u_all (
    .clk400Hz(clk), .rst(rst), .in(in_d[1]), .level(lv_d[1]), .press(pr_d[1]), .released(rl_d[1]), .any_pressed(any_d[1]));
  debounce_bank #(.N_CH(4), .DEPTH(DEPTH), .MODE(0), .ACTIVE_LOW(1), .REPEAT_DELAY(200), .REPEAT_RATE(40)) u_any (
    .clk400Hz(clk), .rst(rst), .in(in_d[2]), .level(lv_d[2]), .press(pr_d[2]), .released(rl_d[2]), .any_pressed(any_d[2]));
  debounce_bank #(.N_CH(4), .DEPTH(DEPTH), .MODE(2), .ACTIVE_LOW(0), .REPEAT_DELAY(8), .REPEAT_RATE(3)) u_rep (
    .clk400Hz(clk), .rst(rst), .in(in_d[3]), .level(lv_d[3]), .press(pr_d[3]), .released(rl_d[3]), .any_pressed(any_d[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N_DUT; d++) begin
      for (int c = 0; c < 4; c++) begin
        samp[d][c] = 16'h0000;
        held[d][c] = 0;
      end
      lv_m[d] = 4'h0; pr_m[d] = 4'h0; rl_m[d] = 4'h0; any_m[d] = 1'b0;
    end
  endtask

  // Level after an edge is decided by the DEPTH logical samples taken 3..DEPTH+2 edges earlier.
  task automatic model_step();
    for (int d = 0; d < N_DUT; d++) begin
      for (int c = 0; c < 4; c++) begin
        int   ones;
        logic old;
        logic nw;
        logic rep;
        samp[d][c] = {samp[d][c][14:0], in_d[d][c] ^ m_al[d]};
        ones = 0;
        for (int i = 3; i < DEPTH + 3; i++) ones += int'(samp[d][c][i]);
        old = lv_m[d][c];
        if (m_mode[d] == 0) nw = (ones > 0);
        else if (m_mode[d] == 1) nw = (ones == DEPTH);
        else if (ones == DEPTH) nw = 1'b1;
        else if (ones == 0) nw = 1'b0;
        else nw = old;
        rep = 1'b0;
        if (nw && !old) held[d][c] = 0;
        else if (nw && old) begin
          held[d][c]++;
          rep = REP_EN && (held[d][c] == m_delay[d] ||
                (held[d][c] > m_delay[d] && (held[d][c] - m_delay[d]) % m_rate[d] == 0));
        end else held[d][c] = 0;
        lv_m[d][c] = nw;
        pr_m[d][c] = (nw && !old) || rep;
        rl_m[d][c] = !nw && old;
      end
      any_m[d] = |lv_m[d];
    end
  endtask

  task automatic model_compare();
    for (int d = 0; d < N_DUT; d++) begin
      chk($sformatf("model_level_d%0d", d), lv_d[d], lv_m[d]);
      chk($sformatf("model_press_d%0d", d), pr_d[d], pr_m[d]);
      chk($sformatf("model_release_d%0d", d), rl_d[d], rl_m[d]);
      chk($sformatf("model_any_d%0d", d), {3'b000, any_d[d]}, {3'b000, any_m[d]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step();
    model_compare();
  endtask

  task automatic set_idle();
    in_d[0] = 4'h0; in_d[1] = 4'h0; in_d[2] = 4'hF; in_d[3] = 4'h0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      chk("reset_level", lv_d[d], 4'h0);
      chk("reset_press", pr_d[d], 4'h0);
      chk("reset_release", rl_d[d], 4'h0);
      chk("reset_any", {3'b000, any_d[d]}, 4'h0);
    end
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  initial begin
    // Test 2/3 table for u_hyst channel 1; channel 0 toggling is overlaid in the loop.
    tbl[0] = '{10, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{6,  4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{1,  4'h2, 4'h2, 4'h2, 4'h0, 1'b1};
    tbl[3] = '{13, 4'h2, 4'h2, 4'h0, 4'h0, 1'b1};
    tbl[4] = '{6,  4'h0, 4'h2, 4'h0, 4'h0, 1'b1};
    tbl[5] = '{1,  4'h0, 4'h0, 4'h0, 4'h2, 1'b0};
    tbl[6] = '{4,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    // Test 1: all keys logically pressed throughout reset.
    rst = 1'b1;
    in_d[0] = 4'hF; in_d[1] = 4'hF; in_d[2] = 4'h0; in_d[3] = 4'hF;
    model_reset();
    repeat (3) tick();
    for (int d = 0; d < N_DUT; d++) chk("t1_level_in_reset", lv_d[d], 4'h0);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("t1_press_hyst", pr_d[0], (e == 6) ? 4'hF : 4'h0);
      chk("t1_press_all", pr_d[1], (e == 6) ? 4'hF : 4'h0);
      chk("t1_press_any", pr_d[2], (e == 3) ? 4'hF : 4'h0);
      chk("t1_any_pressed_any", {3'b000, any_d[2]}, (e >= 3) ? 4'h1 : 4'h0);
    end

    // Tests 2 and 3 on u_hyst.
    set_idle();
    do_reset(2);
    begin
      int e;
      e = 0;
      for (int r = 0; r < 7; r++) begin
        for (int j = 0; j < tbl[r].n; j++) begin
          in_d[0] = tbl[r].in | ((e < 20) ? {3'b000, ~e[0]} : 4'h0);
          tick();
          chk("t3_level", lv_d[0], tbl[r].lv);
          chk("t3_press", pr_d[0], tbl[r].pr);
          chk("t3_release", rl_d[0], tbl[r].rl);
          chk("t3_any", {3'b000, any_d[0]}, {3'b000, tbl[r].any});
          e++;
        end
      end
    end

    // Test 4: ALL mode, one-cycle glitch at edge 10.
    set_idle();
    do_reset(2);
    for (int e = 0; e < 21; e++) begin
      in_d[1] = (e == 10) ? 4'h0 : 4'h4;
      tick();
      chk("t4_level", lv_d[1], (e >= 6 && !(e >= 13 && e <= 16)) ? 4'h4 : 4'h0);
      chk("t4_press", pr_d[1], (e == 6 || e == 17) ? 4'h4 : 4'h0);
      chk("t4_release", rl_d[1], (e == 13) ? 4'h4 : 4'h0);
    end

    // Test 5: held key on the short-repeat instance.
    set_idle();
    do_reset(2);
    for (int e = 0; e < 41; e++) begin
      in_d[3] = (e < 30) ? 4'h8 : 4'h0;
      tick();
      chk("t5_press", pr_d[3],
          ((e == 6) || (REP_EN && e >= 14 && e <= 35 && (e - 14) % 3 == 0)) ? 4'h8 : 4'h0);
      chk("t5_release", rl_d[3], (e == 36) ? 4'h8 : 4'h0);
    end

    // Test 6: ANY active-low stretch, then reset in the middle of the stretched pulse.
    set_idle();
    do_reset(2);
    for (int e = 0; e < 10; e++) begin
      in_d[2] = (e == 5) ? 4'hE : 4'hF;
      tick();
      chk("t6_level", lv_d[2], (e >= 8) ? 4'h1 : 4'h0);
      chk("t6_press", pr_d[2], (e == 8) ? 4'h1 : 4'h0);
    end
    do_reset(2);
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("t6_no_release", rl_d[2], 4'h0);
      chk("t6_level_after", lv_d[2], 4'h0);
    end

    // Random stimulus: each input holds a value for 1..9 edges; one reset midway.
    for (int d = 0; d < N_DUT; d++) for (int c = 0; c < 4; c++) hold_cnt[d][c] = 0;
    for (int e = 0; e < 400; e++) begin
      for (int d = 0; d < N_DUT; d++) begin
        for (int c = 0; c < 4; c++) begin
          if (hold_cnt[d][c] == 0) begin
            in_d[d][c] = ($urandom_range(0, 1) == 1);
            hold_cnt[d][c] = int'($urandom_range(1, 9));
          end
          hold_cnt[d][c]--;
        end
      end
      if (e == 200) do_reset(1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
